// File: rtl/upsp_frame_sequencer_pkg.sv
// Shared types and constants for the UPSP frame sequencer: FSM state
// enum, status-word bit positions, default status CRF address.
package upsp_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DRAIN,
    SEQ_DONE
  } seq_state_e;

  localparam int unsigned STAT_DONE_BIT    = 0;
  localparam int unsigned STAT_TLAST_BIT   = 1;
  localparam int unsigned STAT_TIMEOUT_BIT = 2;

  localparam logic [3:0] STATUS_ADDR_DEFAULT = 4'h2;

  function automatic int unsigned beats_per_frame(input int unsigned w,
                                                  input int unsigned h,
                                                  input int unsigned n);
    return (w * h) / n;
  endfunction

endpackage

// File: rtl/upsp_frame_sequencer_if.sv
// Stream-side handshake bundle between the upscaler datapath and its
// frame sequencer.
interface upsp_frame_sequencer_if;

  logic axisi_hsk;
  logic axiso_hsk;
  logic axiso_tlast;
  logic seq_in_en;

  // master: the sequencer, which gates input acceptance
  modport master (
    input  axisi_hsk,
    input  axiso_hsk,
    input  axiso_tlast,
    output seq_in_en
  );

  // slave: the stream datapath reporting handshakes
  modport slave (
    output axisi_hsk,
    output axiso_hsk,
    output axiso_tlast,
    input  seq_in_en
  );

endinterface

// File: rtl/upsp_frame_sequencer_beat_counter.sv
// Saturating beat counter: synchronous clear, increment, holds at LIMIT.
module upsp_beat_counter #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             at_limit_o
);

  logic [CNT_W-1:0] count_q, count_d;

  assign count_o    = count_q;
  assign at_limit_o = (count_q == CNT_W'(LIMIT));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !at_limit_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/upsp_frame_sequencer.sv
// Frame sequencer for the upscaler: counts input/output beats of one frame
// and reports a status word to the CRF. Watchdog enabled by UPSP_SEQ_WATCHDOG_EN.
module upsp_frame_sequencer
  import upsp_seq_pkg::*;
#(
  parameter int unsigned CRF_DATA_WIDTH = 32,
  parameter int unsigned CRF_ADDR_WIDTH = 4,
  parameter int unsigned SRC_IMG_WIDTH  = 960,
  parameter int unsigned SRC_IMG_HEIGHT = 540,
  parameter int unsigned DST_IMG_WIDTH  = 3840,
  parameter int unsigned DST_IMG_HEIGHT = 2160,
  parameter int unsigned N_PARALLEL     = 4,
  parameter logic [CRF_ADDR_WIDTH-1:0] STATUS_ADDR = CRF_ADDR_WIDTH'(STATUS_ADDR_DEFAULT),
  parameter int unsigned WDT_CYCLES     = 65536
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      crf_seq_UPSTART,
  upsp_frame_sequencer_if.master    strm_if,
  output logic                      seq_processing,
  output logic                      seq_crf_wrt,
  output logic [CRF_ADDR_WIDTH-1:0] seq_crf_waddr,
  output logic [CRF_DATA_WIDTH-1:0] seq_crf_wdata,
  output logic                      seq_irq
);

  localparam int unsigned IN_BEATS  = beats_per_frame(SRC_IMG_WIDTH, SRC_IMG_HEIGHT, N_PARALLEL);
  localparam int unsigned OUT_BEATS = beats_per_frame(DST_IMG_WIDTH, DST_IMG_HEIGHT, N_PARALLEL);
  localparam int unsigned IN_W      = $clog2(IN_BEATS + 1);
  localparam int unsigned OUT_W     = $clog2(OUT_BEATS + 1);

  seq_state_e state_q, state_d;
  logic       upstart_q;
  logic       tlast_err_q, tlast_err_d;

  logic             active, start;
  logic             in_inc, in_last, in_at_limit;
  logic             out_inc, out_final, out_last, out_at_limit;
  logic [IN_W-1:0]  in_cnt;
  logic [OUT_W-1:0] out_cnt;
  logic             wdt_expire, timeout;

  assign active  = (state_q == SEQ_RUN) || (state_q == SEQ_DRAIN);
  assign start   = (state_q == SEQ_IDLE) && crf_seq_UPSTART && !upstart_q;

  assign in_inc  = (state_q == SEQ_RUN) && strm_if.axisi_hsk && !in_at_limit;
  assign in_last = in_inc && (in_cnt == IN_W'(IN_BEATS - 1));

  assign out_inc   = active && strm_if.axiso_hsk && !out_at_limit;
  assign out_final = (out_cnt == OUT_W'(OUT_BEATS - 1));
  assign out_last  = out_inc && out_final;

  assign strm_if.seq_in_en = (state_q == SEQ_RUN);
  assign seq_processing    = active;

  upsp_beat_counter #(
    .LIMIT (IN_BEATS),
    .CNT_W (IN_W)
  ) u_in_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (start),
    .inc_i      (in_inc),
    .count_o    (in_cnt),
    .at_limit_o (in_at_limit)
  );

  upsp_beat_counter #(
    .LIMIT (OUT_BEATS),
    .CNT_W (OUT_W)
  ) u_out_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (start),
    .inc_i      (out_inc),
    .count_o    (out_cnt),
    .at_limit_o (out_at_limit)
  );

`ifdef UPSP_SEQ_WATCHDOG_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             timeout_q, timeout_d;

  // Expires on the WDT_CYCLES-th consecutive cycle without any handshake.
  always_comb begin
    wdt_d      = wdt_q;
    timeout_d  = timeout_q;
    wdt_expire = 1'b0;
    if (start) begin
      wdt_d     = '0;
      timeout_d = 1'b0;
    end else if (active) begin
      if (strm_if.axisi_hsk || strm_if.axiso_hsk) begin
        wdt_d = '0;
      end else if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
        wdt_expire = 1'b1;
        timeout_d  = 1'b1;
      end else begin
        wdt_d = wdt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdt_q     <= wdt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  localparam int unsigned UNUSED_WDT_CYCLES = WDT_CYCLES;

  assign wdt_expire = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    tlast_err_d   = tlast_err_q;
    seq_crf_wrt   = 1'b0;
    seq_crf_waddr = '0;
    seq_crf_wdata = '0;
    seq_irq       = 1'b0;

    // tlast must appear on the final beat and nowhere else
    if (out_inc && (strm_if.axiso_tlast != out_final)) begin
      tlast_err_d = 1'b1;
    end

    unique case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          state_d     = SEQ_RUN;
          tlast_err_d = 1'b0;
        end
      end
      SEQ_RUN: begin
        if (out_last || wdt_expire) begin
          state_d = SEQ_DONE;
        end else if (in_last) begin
          state_d = SEQ_DRAIN;
        end
      end
      SEQ_DRAIN: begin
        if (out_last || wdt_expire) begin
          state_d = SEQ_DONE;
        end
      end
      SEQ_DONE: begin
        state_d                         = SEQ_IDLE;
        seq_crf_wrt                     = 1'b1;
        seq_crf_waddr                   = STATUS_ADDR;
        seq_crf_wdata[STAT_DONE_BIT]    = 1'b1;
        seq_crf_wdata[STAT_TLAST_BIT]   = tlast_err_q;
        seq_crf_wdata[STAT_TIMEOUT_BIT] = timeout;
        seq_irq                         = 1'b1;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEQ_IDLE;
      upstart_q   <= 1'b0;
      tlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      upstart_q   <= crf_seq_UPSTART;
      tlast_err_q <= tlast_err_d;
    end
  end

endmodule

// File: tb/tb_upsp_frame_sequencer.sv
// Self-checking bench for upsp_frame_sequencer (SRC 4x4, DST 16x16, N 4,
// WDT 16): frame-level reference model plus directed literal checks.
module tb_upsp_frame_sequencer;

  localparam int unsigned IN_BEATS  = 4;   // 4*4/4
  localparam int unsigned OUT_BEATS = 64;  // 16*16/4
  localparam int unsigned WDT       = 16;

  logic        clk;
  logic        rst_n;
  logic        upstart;
  logic        seq_processing;
  logic        seq_crf_wrt;
  logic [3:0]  seq_crf_waddr;
  logic [31:0] seq_crf_wdata;
  logic        seq_irq;

  upsp_frame_sequencer_if strm ();

  upsp_frame_sequencer #(
    .CRF_DATA_WIDTH (32),
    .CRF_ADDR_WIDTH (4),
    .SRC_IMG_WIDTH  (4),
    .SRC_IMG_HEIGHT (4),
    .DST_IMG_WIDTH  (16),
    .DST_IMG_HEIGHT (16),
    .N_PARALLEL     (4),
    .STATUS_ADDR    (4'h2),
    .WDT_CYCLES     (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .crf_seq_UPSTART (upstart),
    .strm_if         (strm),
    .seq_processing  (seq_processing),
    .seq_crf_wrt     (seq_crf_wrt),
    .seq_crf_waddr   (seq_crf_waddr),
    .seq_crf_wdata   (seq_crf_wdata),
    .seq_irq         (seq_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model: a frame opens on an UPSTART rising edge,
  // accepts IN_BEATS inputs, closes after OUT_BEATS outputs (or watchdog),
  // then reports once.
  bit          m_open    = 1'b0;
  bit          m_closed  = 1'b0;
  bit          m_report  = 1'b0;
  bit          m_err     = 1'b0;
  bit          m_tmo     = 1'b0;
  bit          m_up      = 1'b0;
  bit          m_rise;
  bit          m_finished;
  int unsigned m_in      = 0;
  int unsigned m_out     = 0;
  int unsigned m_idle    = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_open = 0; m_closed = 0; m_report = 0; m_err = 0; m_tmo = 0; m_up = 0;
        m_in = 0; m_out = 0; m_idle = 0;
      end else begin
        m_rise = upstart && !m_up;
        m_up   = upstart;
        if (m_report) begin
          m_report = 0;
        end else if (!m_open) begin
          if (m_rise) begin
            m_open = 1; m_closed = 0; m_err = 0; m_tmo = 0;
            m_in = 0; m_out = 0; m_idle = 0;
          end
        end else begin
          m_finished = 0;
          if (strm.axisi_hsk && !m_closed && m_in < IN_BEATS) begin
            m_in++;
            if (m_in == IN_BEATS) m_closed = 1;
          end
          if (strm.axiso_hsk) begin
            m_out++;
            if ((m_out == OUT_BEATS) != strm.axiso_tlast) m_err = 1;
            if (m_out == OUT_BEATS) m_finished = 1;
          end
`ifdef UPSP_SEQ_WATCHDOG_EN
          if (strm.axisi_hsk || strm.axiso_hsk) begin
            m_idle = 0;
          end else begin
            m_idle++;
            if (m_idle >= WDT) begin
              m_tmo      = 1;
              m_finished = 1;
            end
          end
`endif
          if (m_finished) begin
            m_open   = 0;
            m_closed = 1;
            m_report = 1;
          end
        end
      end
    end
  end

  int unsigned wr_count  = 0;
  int unsigned irq_count = 0;
  logic [31:0] last_wdata = '0;

  initial begin
    forever begin
      @(negedge clk);
      check("in_en",      {31'd0, strm.seq_in_en}, {31'd0, m_open && !m_closed});
      check("processing", {31'd0, seq_processing}, {31'd0, m_open});
      check("crf_wrt",    {31'd0, seq_crf_wrt},    {31'd0, m_report});
      check("crf_waddr",  {28'd0, seq_crf_waddr},  m_report ? 32'h2 : 32'h0);
      check("crf_wdata",  seq_crf_wdata,           m_report ? {29'd0, m_tmo, m_err, 1'b1} : 32'h0);
      check("irq",        {31'd0, seq_irq},        {31'd0, m_report});
      if (seq_crf_wrt) begin
        wr_count++;
        last_wdata = seq_crf_wdata;
      end
      if (seq_irq) irq_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ih, input bit oh, input bit tl);
    strm.axisi_hsk   = ih;
    strm.axiso_hsk   = oh;
    strm.axiso_tlast = tl;
    tick();
  endtask

  task automatic start_frame();
    upstart = 1'b0;
    tick();
    upstart = 1'b1;
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_en"}, {31'd0, strm.seq_in_en}, 32'd0);
    check({tag, "_proc"},  {31'd0, seq_processing}, 32'd0);
    check({tag, "_wrt"},   {31'd0, seq_crf_wrt},    32'd0);
    check({tag, "_waddr"}, {28'd0, seq_crf_waddr},  32'd0);
    check({tag, "_wdata"}, seq_crf_wdata,           32'd0);
    check({tag, "_irq"},   {31'd0, seq_irq},        32'd0);
  endtask

  int unsigned wr_before;

  initial begin
    rst_n            = 1'b0;
    upstart          = 1'b0;
    strm.axisi_hsk   = 1'b0;
    strm.axiso_hsk   = 1'b0;
    strm.axiso_tlast = 1'b0;
    #1;
    check_outputs_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Nominal frame; UPSTART stays high afterwards and must not restart.
    start_frame();
    for (int i = 0; i < 4; i++) drive(1, 0, 0);
    for (int i = 1; i <= 64; i++) drive(0, 1, i == 64);
    drive(0, 0, 0);
    check("nom_wr_count", wr_count, 32'd1);
    check("nom_wdata",    last_wdata, 32'h1);
    check("nom_irq",      irq_count, 32'd1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0);
    check("held_no_restart", {31'd0, seq_processing}, 32'd0);

    // Concurrent input/output, plus a 5th input beat offered after the 4th.
    start_frame();
    for (int i = 0; i < 4; i++) drive(1, 1, 0);
    check("fifth_in_en", {31'd0, strm.seq_in_en}, 32'd0);
    drive(1, 1, 0);
    for (int i = 6; i <= 64; i++) drive(0, 1, i == 64);
    drive(0, 0, 0);
    check("conc_wr_count", wr_count, 32'd2);
    check("conc_wdata",    last_wdata, 32'h1);

    // tlast only on beat 10.
    start_frame();
    for (int i = 0; i < 4; i++) drive(1, 0, 0);
    for (int i = 1; i <= 64; i++) drive(0, 1, i == 10);
    drive(0, 0, 0);
    check("tlast_wr_count", wr_count, 32'd3);
    check("tlast_wdata",    last_wdata, 32'h3);
    check("tlast_irq",      irq_count, 32'd3);

    // Stall after 2 input beats.
    start_frame();
    for (int i = 0; i < 2; i++) drive(1, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 0);
`ifdef UPSP_SEQ_WATCHDOG_EN
    check("wdt_wr_count", wr_count, 32'd4);
    check("wdt_wdata",    last_wdata, 32'h5);
    check("wdt_irq",      irq_count, 32'd4);
    check("wdt_idle",     {31'd0, seq_processing}, 32'd0);
`else
    check("nowdt_wr_count", wr_count, 32'd3);
    check("nowdt_running",  {31'd0, seq_processing}, 32'd1);
    check("nowdt_in_en",    {31'd0, strm.seq_in_en}, 32'd1);
`endif

    rst_n   = 1'b0;
    upstart = 1'b0;
    #1;
    check_outputs_zero("rst1");
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in DRAIN at output beat 30, then a fresh frame.
    start_frame();
    for (int i = 0; i < 4; i++) drive(1, 0, 0);
    for (int i = 1; i <= 30; i++) drive(0, 1, 0);
    check("drain_before_rst", {31'd0, seq_processing}, 32'd1);
    wr_before = wr_count;
    rst_n   = 1'b0;
    upstart = 1'b0;
    #1;
    check_outputs_zero("rst2");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("rst2_no_wrt", wr_count, wr_before);
    upstart = 1'b1;
    tick();
    check("fresh_proc",  {31'd0, seq_processing}, 32'd1);
    check("fresh_in_en", {31'd0, strm.seq_in_en}, 32'd1);
    for (int i = 0; i < 4; i++) drive(1, 0, 0);
    for (int i = 1; i <= 64; i++) drive(0, 1, i == 64);
    drive(0, 0, 0);
    check("fresh_wr_count", wr_count, wr_before + 1);
    check("fresh_wdata",    last_wdata, 32'h1);
    drive(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/upsp_frame_sequencer.md
UPSP_FRAME_SEQUENCER -- requirements
Module: upsp_frame_sequencer

Interface
REQ-001 SHALL have parameter CRF_DATA_WIDTH, default 32, CRF write-data width.
REQ-002 SHALL have parameter CRF_ADDR_WIDTH, default 4, CRF write-address width.
REQ-003 SHALL have parameters SRC_IMG_WIDTH/SRC_IMG_HEIGHT, default 960/540, source frame size in pixels.
REQ-004 SHALL have parameters DST_IMG_WIDTH/DST_IMG_HEIGHT, default 3840/2160, destination frame size in pixels.
REQ-005 SHALL have parameter N_PARALLEL, default 4, pixels per AXI-Stream beat.
REQ-006 SHALL have parameter STATUS_ADDR, default 4'h2, CRF address receiving the status word.
REQ-007 SHALL have parameter WDT_CYCLES, default 65536, idle-cycle watchdog limit.
REQ-008 clk  in  1  single clock; all state on rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 crf_seq_UPSTART  in  1  start level from CRF.
REQ-011 axisi_hsk  in  1  input stream handshake (tvalid&tready) this cycle.
REQ-012 axiso_hsk  in  1  output stream handshake this cycle.
REQ-013 axiso_tlast  in  1  tlast of output beat; sampled only with axiso_hsk.
REQ-014 seq_in_en  out  1  permits input tready; low stops input acceptance.
REQ-015 seq_processing  out  1  frame in progress.
REQ-016 seq_crf_wrt  out  1  one-cycle CRF write strobe.
REQ-017 seq_crf_waddr  out  CRF_ADDR_WIDTH  CRF write address.
REQ-018 seq_crf_wdata  out  CRF_DATA_WIDTH  status word: bit0 done, bit1 tlast error, bit2 timeout, others 0.
REQ-019 seq_irq  out  1  one-cycle completion pulse.

Function
REQ-020 States SHALL be IDLE, RUN, DRAIN, DONE; encoding free.
REQ-021 IN_BEATS = SRC_IMG_WIDTH*SRC_IMG_HEIGHT/N_PARALLEL; OUT_BEATS = DST_IMG_WIDTH*DST_IMG_HEIGHT/N_PARALLEL; counters sized $clog2(beats+1), no wrap.
REQ-022 IDLE->RUN on rising edge of crf_seq_UPSTART (registered previous value); level held high SHALL NOT restart; edges outside IDLE ignored.
REQ-023 On IDLE->RUN both beat counters, error flags and watchdog SHALL clear.
REQ-024 seq_in_en SHALL be 1 only in RUN; axisi_hsk outside RUN ignored.
REQ-025 RUN->DRAIN in the cycle after input count reaches IN_BEATS; seq_in_en low from that cycle (registered, zero-cycle-early not required).
REQ-026 axiso_hsk counted in RUN and DRAIN; same-cycle axisi_hsk and axiso_hsk SHALL both count.
REQ-027 Output count reaching OUT_BEATS SHALL move to DONE from RUN or DRAIN; tlast error set if final beat lacks tlast or any earlier beat has tlast.
REQ-028 DONE lasts exactly one cycle: seq_crf_wrt=1, seq_crf_waddr=STATUS_ADDR, seq_crf_wdata={0..,timeout,tlast_err,1}, seq_irq=1; then IDLE.
REQ-029 seq_processing SHALL be 1 in RUN and DRAIN, 0 otherwise.
REQ-030 Output beats beyond OUT_BEATS cannot occur (state left); input beats past IN_BEATS cannot count.

Reset
REQ-031 On rst_n low, state IDLE, counters 0, flags 0, UPSTART history 0, all outputs 0 immediately (async).
REQ-032 Reset mid-frame SHALL abandon the frame without a CRF write or irq.

Configuration
REQ-033 With UPSP_SEQ_WATCHDOG_EN defined: counter counts cycles in RUN/DRAIN with neither handshake, clears on any handshake; at WDT_CYCLES sets timeout and enters DONE.
REQ-034 Without UPSP_SEQ_WATCHDOG_EN: no watchdog logic, status bit2 constant 0, frames wait indefinitely.

Structure
REQ-035 State enum, status bit indices and STATUS_ADDR default SHALL live in package upsp_seq_pkg.
REQ-036 Sub-module upsp_beat_counter (saturating counter with clear/inc/at_limit) SHALL be instantiated twice.

Verification (SRC 4x4, DST 16x16, N_PARALLEL 4: IN_BEATS 4, OUT_BEATS 64; WDT_CYCLES 16)
REQ-037 Nominal: UPSTART edge, 4 input beats, 64 output beats with tlast on 64th -> one-cycle wrt at addr 2, wdata 0x1, irq pulse, back to IDLE.
REQ-038 Concurrent: input and output handshakes in same cycles -> counts exact, DONE after 64th output, wdata 0x1.
REQ-039 tlast on beat 10 only -> wdata 0x3 at completion.
REQ-040 Watchdog (macro on): stall 16 cycles after 2 input beats -> wdata 0x5, irq; macro off -> remains in RUN.
REQ-041 UPSTART held high after DONE -> no restart until low then high; 5th input beat offered -> seq_in_en 0, not counted.
REQ-042 rst_n asserted in DRAIN at output beat 30 -> outputs 0 at once, no wrt/irq, next UPSTART edge starts a fresh frame.
